// File: rtl/sram_arb_pkg.sv
// Shared widths and read-owner encoding for the SRAM arbiter slice.
package sram_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Counts consecutive denied DMA request cycles; o_force says DMA must win now.
module sram_arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_dma_req,
  input  logic i_dma_gnt,
  output logic o_force
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Any grant or a dropped request ends the starvation run.
  always_ff @(posedge clk) begin
    if (reset || !i_dma_req || i_dma_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt < CW'(LIMIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_force = i_dma_req && (r_cnt == CW'(LIMIT));

endmodule

// File: rtl/sram_arbiter.sv
// Single-port SRAM arbiter, CPU priority with zero-latency command issue.
// Optional DMA starvation guard compiled in with SRAM_ARB_STARVE_GUARD_EN.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_di,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_di,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] sram_ADDR,
  output logic [DATA_W-1:0] sram_DI,
  output logic              sram_EN,
  output logic              sram_WE,
  input  logic [DATA_W-1:0] sram_DO,
  output logic [DATA_W-1:0] rdata,
  output owner_e            o_dbg_owner
);

  logic   w_force;
  logic   w_cpu_win;
  logic   w_dma_win;
  owner_e r_owner;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  sram_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_dma_req (dma_req),
    .i_dma_gnt (w_dma_win),
    .o_force   (w_force)
  );
`else
  logic w_unused_starve_limit;
  assign w_unused_starve_limit = (STARVE_LIMIT == 0);
  assign w_force = 1'b0;
`endif

  // Reset masks both grants so nothing reaches the SRAM while it is held.
  assign w_dma_win = !reset && dma_req && (!cpu_req || w_force);
  assign w_cpu_win = !reset && cpu_req && !w_dma_win;

  assign cpu_gnt = w_cpu_win;
  assign dma_gnt = w_dma_win;

  always_comb begin
    sram_EN   = 1'b0;
    sram_WE   = 1'b0;
    sram_ADDR = '0;
    sram_DI   = '0;
    if (w_cpu_win) begin
      sram_EN   = 1'b1;
      sram_WE   = cpu_we;
      sram_ADDR = cpu_addr;
      sram_DI   = cpu_di;
    end else if (w_dma_win) begin
      sram_EN   = 1'b1;
      sram_WE   = dma_we;
      sram_ADDR = dma_addr;
      sram_DI   = dma_di;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner <= OWN_NONE;
    end else if (w_cpu_win && !cpu_we) begin
      r_owner <= OWN_CPU;
    end else if (w_dma_win && !dma_we) begin
      r_owner <= OWN_DMA;
    end else begin
      r_owner <= OWN_NONE;
    end
  end

  // Reset in the data-return cycle drops the pending read result.
  assign cpu_rvalid  = !reset && (r_owner == OWN_CPU);
  assign dma_rvalid  = !reset && (r_owner == OWN_DMA);
  assign rdata       = sram_DO;
  assign o_dbg_owner = r_owner;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed steps then random traffic against a reference model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int LIMIT = 4;
`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              cpu_req, cpu_we, dma_req, dma_we;
  logic [ADDR_W-1:0] cpu_addr, dma_addr;
  logic [DATA_W-1:0] cpu_di, dma_di;
  logic              cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [ADDR_W-1:0] sram_ADDR;
  logic [DATA_W-1:0] sram_DI, sram_DO, rdata;
  logic              sram_EN, sram_WE;
  owner_e            dbg_owner;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_di     (cpu_di),
    .cpu_gnt    (cpu_gnt),
    .cpu_rvalid (cpu_rvalid),
    .dma_req    (dma_req),
    .dma_we     (dma_we),
    .dma_addr   (dma_addr),
    .dma_di     (dma_di),
    .dma_gnt    (dma_gnt),
    .dma_rvalid (dma_rvalid),
    .sram_ADDR  (sram_ADDR),
    .sram_DI    (sram_DI),
    .sram_EN    (sram_EN),
    .sram_WE    (sram_WE),
    .sram_DO    (sram_DO),
    .rdata      (rdata),
    .o_dbg_owner(dbg_owner)
  );

  // SRAM device: one-cycle read latency
  logic [DATA_W-1:0] mem [0:255];
  always @(posedge clk) begin
    if (sram_EN) begin
      if (sram_WE) mem[sram_ADDR[7:0]] <= sram_DI;
      else         sram_DO <= mem[sram_ADDR[7:0]];
    end
  end

  // reference model state and scoreboard
  logic [DATA_W-1:0] ref_mem [0:255];
  logic [DATA_W-1:0] exp_q[$];
  bit pend_cpu, pend_dma;
  int deny_run;
  int n_cmp, n_err;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: inputs already applied; check mid-cycle, advance model, cross the edge
  task automatic tick();
    bit dma_win, cpu_win;
    logic [DATA_W-1:0] e_addr, e_di, e_rd;
    @(negedge clk);
    if (reset) begin
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dma_gnt", dma_gnt, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_dma_rvalid", dma_rvalid, 0);
      chk("rst_en", sram_EN, 0);
      chk("rst_we", sram_WE, 0);
      chk("rst_addr", sram_ADDR, 0);
      chk("rst_di", sram_DI, 0);
      pend_cpu = 0;
      pend_dma = 0;
      deny_run = 0;
      exp_q.delete();
    end else begin
      dma_win = dma_req && (!cpu_req || (GUARD && deny_run >= LIMIT));
      cpu_win = cpu_req && !dma_win;
      e_addr  = cpu_win ? 32'(cpu_addr) : dma_win ? 32'(dma_addr) : 32'd0;
      e_di    = cpu_win ? cpu_di : dma_win ? dma_di : 32'd0;
      chk("cpu_gnt", cpu_gnt, cpu_win);
      chk("dma_gnt", dma_gnt, dma_win);
      chk("sram_en", sram_EN, cpu_win || dma_win);
      chk("sram_we", sram_WE, (cpu_win && cpu_we) || (dma_win && dma_we));
      chk("sram_addr", sram_ADDR, e_addr);
      chk("sram_di", sram_DI, e_di);
      chk("cpu_rvalid", cpu_rvalid, pend_cpu);
      chk("dma_rvalid", dma_rvalid, pend_dma);
      if (pend_cpu || pend_dma) begin
        if (exp_q.size() == 0) chk("rdata_q_empty", 1, 0);
        else begin
          e_rd = exp_q.pop_front();
          chk("rdata", rdata, e_rd);
        end
      end
      pend_cpu = cpu_win && !cpu_we;
      pend_dma = dma_win && !dma_we;
      if (cpu_win || dma_win) begin
        if (sram_WE === 1'b1 || (cpu_win ? cpu_we : dma_we))
          ref_mem[e_addr[7:0]] = e_di;
        else
          exp_q.push_back(ref_mem[e_addr[7:0]]);
      end
      if (dma_req && !dma_win) deny_run = (deny_run + 1 > LIMIT) ? LIMIT : deny_run + 1;
      else                     deny_run = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_di = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_di = '0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; deny_run = 0; pend_cpu = 0; pend_dma = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    idle();
    reset = 1'b1;
    // reset with both requesters active
    cpu_req = 1; dma_req = 1; cpu_addr = 16'h0003; dma_addr = 16'h0004;
    tick(); tick();
    reset = 1'b0;
    idle();
    tick();

    // lone CPU read
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    tick();
    idle();
    tick();

    // CPU read collides with DMA write; DMA holds its request
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0001;
    dma_req = 1; dma_we = 1; dma_addr = 16'h0020; dma_di = 32'hDEADBEEF;
    tick();
    cpu_req = 0;
    tick();
    idle();
    tick();
    cpu_req = 1; cpu_addr = 16'h0020;
    tick();
    idle();
    tick();

    // continuous contention: starvation guard behaviour
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0005;
    dma_req = 1; dma_we = 0; dma_addr = 16'h0006;
    for (int i = 0; i < 12; i++) tick();
    idle();
    tick();

    // ten idle cycles
    for (int i = 0; i < 10; i++) tick();

    // DMA read then reset in its data-return cycle
    dma_req = 1; dma_we = 0; dma_addr = 16'h0007;
    tick();
    reset = 1'b1;
    cpu_req = 1;
    tick();
    tick();
    reset = 1'b0;
    idle();
    tick();

    // random traffic with back-to-back and colliding accesses
    for (int i = 0; i < 400; i++) begin
      cpu_req  = ($urandom_range(0, 3) != 0);
      cpu_we   = $urandom_range(0, 1);
      cpu_addr = 16'($urandom_range(0, 15));
      cpu_di   = $urandom;
      dma_req  = ($urandom_range(0, 2) != 0);
      dma_we   = $urandom_range(0, 1);
      dma_addr = 16'($urandom_range(0, 15));
      dma_di   = $urandom;
      reset    = ($urandom_range(0, 63) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
